multisim_push_arbiter: RTL and testbench



---
 rtl/multisim_push_arb_pkg.sv | 43 ++++
 rtl/multisim_push_arbiter_picker.sv | 25 ++
 rtl/multisim_push_arbiter.sv | 141 ++++++++++++++
 tb/tb_multisim_push_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multisim_push_arb_pkg.sv
// Shared types and helpers for the multisim push-channel arbiter.
// Provides the arbiter state type, ID width helper and round-robin pick function.
package multisim_push_arb_pkg;

    localparam int unsigned MAX_REQ      = 32;
    localparam int unsigned MAX_IDX_W    = 5;
    localparam int unsigned MIN_ID_WIDTH = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Source-tag width: ceil(log2(n)), never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 32'($clog2(n));
        return (w < MIN_ID_WIDTH) ? MIN_ID_WIDTH : w;
    endfunction

    // First valid requester at or after ptr, wrapping by explicit compare against n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] vld,
                                                   input int unsigned        ptr,
                                                   input int unsigned        n);
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && vld[MAX_IDX_W'(idx)]) begin
                grant[MAX_IDX_W'(idx)] = 1'b1;
                found                  = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/multisim_push_arbiter_picker.sv
// Combinational round-robin priority select: valid vector and pointer in,
// one-hot grant and its index out. Shared by push- and pull-side arbiters.
module multisim_rr_picker
    import multisim_push_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  vld,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant_c,
    output logic [ID_WIDTH-1:0] idx_c
);

    always_comb begin
        grant_c = NUM_REQ'(rr_pick(MAX_REQ'(vld), 32'(ptr), NUM_REQ));
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_c[ID_WIDTH'(i)]) begin
                idx_c = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/multisim_push_arbiter.sv
// Round-robin, message-atomic arbiter sharing one multisim push channel among NUM_REQ requesters.
// Optional statistics/stability checking enabled by MULTISIM_PUSH_ARB_STATS_EN.
module multisim_push_arbiter
    import multisim_push_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = id_width(NUM_REQ),
    parameter int unsigned OUT_WIDTH  = DATA_WIDTH + ID_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ-1:0]    req_last,
    input  logic [DATA_WIDTH-1:0] req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic                  out_vld,
    output logic [OUT_WIDTH-1:0]  out_data,
    input  logic                  out_rdy
`ifdef MULTISIM_PUSH_ARB_STATS_EN
    ,
    output logic [31:0]           beat_cnt [NUM_REQ],
    output logic [31:0]           stall_cnt
`endif
);

    arb_state_e            state_q,    state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_WIDTH-1:0]   lock_id_q,  lock_id_d;
    logic                  out_vld_q,  out_vld_d;
    logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;

    logic [NUM_REQ-1:0]    pick_grant;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [NUM_REQ-1:0]    lock_grant;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  load_en;
    logic                  accept;

    multisim_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .vld     (req_vld),
        .ptr     (rr_ptr_q),
        .grant_c (pick_grant),
        .idx_c   (pick_idx)
    );

    // Grant selection, output-register load and lock/pointer next-state.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_id_d  = lock_id_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;

        lock_grant            = '0;
        lock_grant[lock_id_q] = 1'b1;
        grant   = (state_q == LOCKED) ? lock_grant : pick_grant;
        sel_id  = (state_q == LOCKED) ? lock_id_q  : pick_idx;
        load_en = !out_vld_q || out_rdy;
        req_rdy = (load_en && !rst) ? grant : '0;
        accept  = |(req_rdy & req_vld);

        if (accept) begin
            out_vld_d  = 1'b1;
            out_data_d = {sel_id, req_data[sel_id]};
            if (req_last[sel_id]) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : sel_id + ID_WIDTH'(1);
            end else begin
                state_d   = LOCKED;
                lock_id_d = sel_id;
            end
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_id_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_id_q  <= lock_id_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;

`ifdef MULTISIM_PUSH_ARB_STATS_EN
    logic [31:0] beat_cnt_q [NUM_REQ];
    logic [31:0] beat_cnt_d [NUM_REQ];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Per-requester beat counters wrap; stall counter saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_vld_q && !out_rdy && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            beat_cnt_d[i] = beat_cnt_q[i] + 32'(req_vld[ID_WIDTH'(i)] && req_rdy[ID_WIDTH'(i)]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                beat_cnt_q[i] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                beat_cnt_q[i] <= beat_cnt_d[i];
            end
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stable
        a_req_stable : assert property (@(posedge clk) disable iff (rst)
            (req_vld[gi] && !req_rdy[gi]) |=>
            (!req_vld[gi] || (req_data[gi] == $past(req_data[gi]) && req_last[gi] == $past(req_last[gi]))));
    end
`endif

endmodule

// File: tb/tb_multisim_push_arbiter.sv
// Bench for multisim_push_arbiter: hand-derived vector table, a 3-requester wrap
// sequence, and randomized traffic checked against a cycle-level reference model.
module tb_multisim_push_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 64;
    localparam int unsigned OW  = 66;
    localparam int unsigned N3  = 3;
    localparam int unsigned DW3 = 8;
    localparam int unsigned OW3 = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_vld, req_last, req_rdy;
    logic [DW-1:0] req_data [N];
    logic          out_vld, out_rdy;
    logic [OW-1:0] out_data;

    logic           rst3;
    logic [N3-1:0]  vld3, last3, rdy3;
    logic [DW3-1:0] data3 [N3];
    logic           ov3, ordy3;
    logic [OW3-1:0] od3;

`ifdef MULTISIM_PUSH_ARB_STATS_EN
    logic [31:0] beat_cnt [N];
    logic [31:0] stall_cnt;
    logic [31:0] beat_cnt3 [N3];
    logic [31:0] stall_cnt3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multisim_push_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last), .req_data(req_data),
        .req_rdy(req_rdy), .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy)
`ifdef MULTISIM_PUSH_ARB_STATS_EN
        , .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
    );

    multisim_push_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW3)) u_dut3 (
        .clk(clk), .rst(rst3), .req_vld(vld3), .req_last(last3), .req_data(data3),
        .req_rdy(rdy3), .out_vld(ov3), .out_data(od3), .out_rdy(ordy3)
`ifdef MULTISIM_PUSH_ARB_STATS_EN
        , .beat_cnt(beat_cnt3), .stall_cnt(stall_cnt3)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: owner-or-round-robin grant from the arbitration rules.
    int            m_owner = -1;
    int            m_ptr   = 0;
    bit            m_vld   = 1'b0;
    logic [OW-1:0] m_data  = '0;
    bit            m_known = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        int           g;
        int           idx;
        bit           load;
        if (m_known) begin
            chk("mdl_out_vld", 128'(out_vld), 128'(m_vld));
            chk("mdl_out_data", 128'(out_data), 128'(m_data));
        end
        if (rst) begin
            chk("mdl_rdy_in_rst", 128'(req_rdy), 128'(0));
            m_vld   = 1'b0;
            m_data  = '0;
            m_owner = -1;
            m_ptr   = 0;
            m_known = 1'b1;
        end else if (m_known) begin
            g = -1;
            if (m_owner >= 0) begin
                g = m_owner;
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    idx = (m_ptr + k) % int'(N);
                    if (g < 0 && req_vld[2'(idx)]) g = idx;
                end
            end
            load = !m_vld || out_rdy;
            er   = '0;
            if (load && g >= 0) er[2'(g)] = 1'b1;
            chk("mdl_req_rdy", 128'(req_rdy), 128'(er));
            if (g >= 0 && er[2'(g)] && req_vld[2'(g)]) begin
                m_data = {2'(g), req_data[2'(g)]};
                m_vld  = 1'b1;
                if (req_last[2'(g)]) begin
                    m_owner = -1;
                    m_ptr   = (g + 1) % int'(N);
                end else begin
                    m_owner = g;
                end
            end else if (out_rdy) begin
                m_vld = 1'b0;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic        rdy;
        logic [31:0] pl;
        logic [3:0]  erdy;
        logic        chk_out;
        logic        eov;
        logic [1:0]  eid;
        logic [7:0]  epl;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic o,
                       input logic [31:0] p, input logic [3:0] er, input logic c,
                       input logic eov, input logic [1:0] eid, input logic [7:0] epl);
        vec_t t;
        t.rst = r; t.vld = v; t.last = l; t.rdy = o; t.pl = p;
        t.erdy = er; t.chk_out = c; t.eov = eov; t.eid = eid; t.epl = epl;
        tbl.push_back(t);
    endtask

    int          rem [N];
    logic [31:0] seq;
    logic [N-1:0] acc;

    initial begin
        rst = 1'b1; req_vld = '0; req_last = '0; out_rdy = 1'b1;
        for (int i = 0; i < int'(N); i++) req_data[i] = '0;
        rst3 = 1'b1; vld3 = '0; last3 = '0; ordy3 = 1'b1;
        for (int i = 0; i < int'(N3); i++) data3[i] = '0;

        // reset
        add(1, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 0, 0, 0, 8'h00);
        add(1, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 0, 8'h00);
        // req2 three-beat message
        add(0, 4'b0100, 4'b0000, 1, 32'h000A0000, 4'b0100, 1, 0, 0, 8'h00);
        add(0, 4'b0100, 4'b0000, 1, 32'h000B0000, 4'b0100, 1, 1, 2, 8'h0A);
        add(0, 4'b0100, 4'b0100, 1, 32'h000C0000, 4'b0100, 1, 1, 2, 8'h0B);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 1, 2, 8'h0C);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 2, 8'h0C);
        // fairness, starting from rr_ptr=3
        add(0, 4'b1111, 4'b1111, 1, 32'h13121110, 4'b1000, 1, 0, 2, 8'h0C);
        add(0, 4'b1111, 4'b1111, 1, 32'h13121110, 4'b0001, 1, 1, 3, 8'h13);
        add(0, 4'b1111, 4'b1111, 1, 32'h13121110, 4'b0010, 1, 1, 0, 8'h10);
        add(0, 4'b1111, 4'b1111, 1, 32'h13121110, 4'b0100, 1, 1, 1, 8'h11);
        add(0, 4'b1111, 4'b1111, 1, 32'h13121110, 4'b1000, 1, 1, 2, 8'h12);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 1, 3, 8'h13);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 3, 8'h13);
        // message lock: req1 waits behind req0's 4 beats
        add(0, 4'b0001, 4'b0000, 1, 32'h00000020, 4'b0001, 1, 0, 3, 8'h13);
        add(0, 4'b0011, 4'b0010, 1, 32'h00003121, 4'b0001, 1, 1, 0, 8'h20);
        add(0, 4'b0011, 4'b0010, 1, 32'h00003122, 4'b0001, 1, 1, 0, 8'h21);
        add(0, 4'b0011, 4'b0011, 1, 32'h00003123, 4'b0001, 1, 1, 0, 8'h22);
        add(0, 4'b0010, 4'b0010, 1, 32'h00003100, 4'b0010, 1, 1, 0, 8'h23);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 1, 1, 8'h31);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 1, 8'h31);
        // backpressure for five cycles
        add(0, 4'b0100, 4'b0100, 1, 32'h00400000, 4'b0100, 1, 0, 1, 8'h31);
        for (int i = 0; i < 5; i++)
            add(0, 4'b1000, 4'b1000, 0, 32'h41000000, 4'b0000, 1, 1, 2, 8'h40);
        add(0, 4'b1000, 4'b1000, 1, 32'h41000000, 4'b1000, 1, 1, 2, 8'h40);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 1, 3, 8'h41);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 3, 8'h41);
        // reset in the middle of req3's message
        add(0, 4'b1000, 4'b0000, 1, 32'h50000000, 4'b1000, 1, 0, 3, 8'h41);
        add(0, 4'b1010, 4'b0010, 1, 32'h51003100, 4'b1000, 1, 1, 3, 8'h50);
        add(1, 4'b1010, 4'b0010, 1, 32'h52003100, 4'b0000, 1, 1, 3, 8'h51);
        add(0, 4'b1010, 4'b0010, 1, 32'h52003100, 4'b0010, 1, 0, 0, 8'h00);
        // lock holds while owner drops valid
        add(0, 4'b1000, 4'b0000, 1, 32'h52000000, 4'b1000, 1, 1, 1, 8'h31);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b1000, 1, 1, 3, 8'h52);
        add(0, 4'b0011, 4'b0011, 1, 32'h00003130, 4'b1000, 1, 0, 3, 8'h52);
        add(0, 4'b1011, 4'b1011, 1, 32'h53003130, 4'b1000, 1, 0, 3, 8'h52);
        add(0, 4'b0011, 4'b0011, 1, 32'h00003130, 4'b0001, 1, 1, 3, 8'h53);
        add(0, 4'b0010, 4'b0010, 1, 32'h00003100, 4'b0010, 1, 1, 0, 8'h30);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 1, 1, 8'h31);
        add(0, 4'b0000, 4'b0000, 1, 32'h0,        4'b0000, 1, 0, 1, 8'h31);

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk); #1;
            rst      = tbl[r].rst;
            req_vld  = tbl[r].vld;
            req_last = tbl[r].last;
            out_rdy  = tbl[r].rdy;
            for (int i = 0; i < int'(N); i++) req_data[i] = 64'(tbl[r].pl[8*i +: 8]);
            @(negedge clk);
            chk($sformatf("tbl%0d_req_rdy", r), 128'(req_rdy), 128'(tbl[r].erdy));
            if (tbl[r].chk_out) begin
                chk($sformatf("tbl%0d_out_vld", r), 128'(out_vld), 128'(tbl[r].eov));
                chk($sformatf("tbl%0d_out_data", r), 128'(out_data), 128'({tbl[r].eid, 64'(tbl[r].epl)}));
            end
`ifdef MULTISIM_PUSH_ARB_STATS_EN
            if (r == 27) chk("stall_cnt", 128'(stall_cnt), 128'd5);
`endif
        end

        // three requesters: wrap from rr_ptr=2 back to 0
        @(posedge clk); #1;
        rst3 = 1'b0; vld3 = 3'b010; last3 = 3'b010; data3[1] = 8'h11;
        @(negedge clk);
        chk("w3_rdy0", 128'(rdy3), 128'(3'b010));
        chk("w3_ov0", 128'(ov3), 128'(0));
        @(posedge clk); #1;
        vld3 = 3'b101; last3 = 3'b101; data3[0] = 8'h20; data3[2] = 8'h22;
        @(negedge clk);
        chk("w3_rdy1", 128'(rdy3), 128'(3'b100));
        chk("w3_od1", 128'(od3), 128'({2'd1, 8'h11}));
        @(posedge clk); #1;
        vld3 = 3'b001; last3 = 3'b001;
        @(negedge clk);
        chk("w3_rdy2", 128'(rdy3), 128'(3'b001));
        chk("w3_od2", 128'(od3), 128'({2'd2, 8'h22}));
        @(posedge clk); #1;
        vld3 = 3'b000;
        @(negedge clk);
        chk("w3_rdy3", 128'(rdy3), 128'(3'b000));
        chk("w3_ov3", 128'(ov3), 128'(1));
        chk("w3_od3", 128'(od3), 128'({2'd0, 8'h20}));

        // randomized traffic, backpressure and occasional resets
        seq = 32'h0;
        for (int i = 0; i < int'(N); i++) rem[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_vld & req_rdy;
            @(posedge clk); #1;
            rst     = ($urandom_range(0, 299) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < int'(N); i++) begin
                if (acc[i]) rem[i]--;
                if (!req_vld[i] || acc[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if (rem[i] <= 0) rem[i] = int'($urandom_range(1, 4));
                        req_vld[i]  = 1'b1;
                        req_last[i] = (rem[i] == 1);
                        req_data[i] = {32'(i), seq};
                        seq         = seq + 32'd1;
                    end else begin
                        req_vld[i] = 1'b0;
                    end
                end
            end
        end

        @(posedge clk); #1;
        rst = 1'b0; req_vld = '0; out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
